// File: rtl/skew_rd_control_pkg.sv
// Shared definitions for the skewed read / result write controllers.
package skew_rd_control_pkg;

  localparam int unsigned WIDTH_HEIGHT_DEF = 16;
  localparam int unsigned ADDR_W_DEF       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter spanning 0 .. 2*w-2.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(2 * w - 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(WIDTH_HEIGHT_DEF);

endpackage

// File: rtl/skew_rd_control_if.sv
// Sequencer <-> skewed read controller bus. With SKEW_RD_STALL_EN defined a
// stall input is added.
interface skew_rd_control_if #(
  parameter int unsigned WIDTH_HEIGHT = skew_rd_control_pkg::WIDTH_HEIGHT_DEF,
  parameter int unsigned ADDR_W       = skew_rd_control_pkg::ADDR_W_DEF
) ();

  logic                           start;
  logic [ADDR_W-1:0]              base_addr;
  logic                           sys_arr_active;
`ifdef SKEW_RD_STALL_EN
  logic                           stall;
`endif
  logic [WIDTH_HEIGHT-1:0]        rd_en;
  logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr;
  logic                           busy;
  logic                           done;

  modport master (
    output start, base_addr, sys_arr_active,
`ifdef SKEW_RD_STALL_EN
    output stall,
`endif
    input  rd_en, rd_addr, busy, done
  );

  modport slave (
    input  start, base_addr, sys_arr_active,
`ifdef SKEW_RD_STALL_EN
    input  stall,
`endif
    output rd_en, rd_addr, busy, done
  );

endinterface

// File: rtl/skew_rd_control_lane.sv
// One memory lane: enabled while 0 <= cnt-LANE < WIDTH_HEIGHT, address base+(cnt-LANE).
module skew_rd_lane #(
  parameter int unsigned LANE         = 0,
  parameter int unsigned WIDTH_HEIGHT = skew_rd_control_pkg::WIDTH_HEIGHT_DEF,
  parameter int unsigned ADDR_W       = skew_rd_control_pkg::ADDR_W_DEF,
  parameter int unsigned CNT_W        = skew_rd_control_pkg::CNT_W_DEF
) (
  input  logic              active_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              en_c_o,
  output logic [ADDR_W-1:0] addr_c_o
);

  // Extra MSB captures the borrow when cnt is still below this lane's start.
  logic [CNT_W:0] diff_c;

  // Lane window decode and address offset.
  always_comb begin
    diff_c   = {1'b0, cnt_i} - (CNT_W+1)'(LANE);
    en_c_o   = 1'b0;
    addr_c_o = '0;
    if (active_i && !diff_c[CNT_W] && (diff_c[CNT_W-1:0] < CNT_W'(WIDTH_HEIGHT))) begin
      en_c_o   = 1'b1;
      addr_c_o = base_i + ADDR_W'(diff_c[CNT_W-1:0]);
    end
  end

endmodule

// File: rtl/skew_rd_control.sv
// Diagonally skewed tile read controller: lane i lags lane 0 by i cycles.
// Optional macro SKEW_RD_STALL_EN adds a stall input that freezes RUN progress.
module skew_rd_control
  import skew_rd_control_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT = WIDTH_HEIGHT_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  skew_rd_control_if.slave  bus
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH_HEIGHT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH_HEIGHT - 2);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [WIDTH_HEIGHT-1:0]        rd_en_q;
  logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr_q;

  logic                           stall_c;
  logic                           run_next_c;
  logic [WIDTH_HEIGHT-1:0]        lane_en_c;
  logic [WIDTH_HEIGHT*ADDR_W-1:0] lane_addr_c;

`ifdef SKEW_RD_STALL_EN
  assign stall_c = bus.stall;
`else
  assign stall_c = 1'b0;
`endif

  // Next-state, counter, base capture and status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (done_q && bus.sys_arr_active) begin
      done_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          base_d  = bus.base_addr;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (!stall_c) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_next_c = (state_d == RUN);

  // Per-lane decode driven from the next count so enables are registered in step.
  for (genvar g = 0; g < int'(WIDTH_HEIGHT); g++) begin : g_lane
    skew_rd_lane #(
      .LANE         (g),
      .WIDTH_HEIGHT (WIDTH_HEIGHT),
      .ADDR_W       (ADDR_W),
      .CNT_W        (CNT_W)
    ) u_lane (
      .active_i (run_next_c),
      .cnt_i    (cnt_d),
      .base_i   (base_d),
      .en_c_o   (lane_en_c[g]),
      .addr_c_o (lane_addr_c[g*ADDR_W +: ADDR_W])
    );
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= lane_en_c;
      rd_addr_q <= lane_addr_c;
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_skew_rd_control.sv
// Directed scoreboard bench for skew_rd_control (W=16, ADDR_W=8).
module tb_skew_rd_control;

  localparam int WH = 16;
  localparam int AW = 8;

  typedef struct packed {
    logic [WH-1:0]    en;
    logic [WH*AW-1:0] addr;
    logic             busy;
    logic             done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  skew_rd_control_if #(.WIDTH_HEIGHT(WH), .ADDR_W(AW)) bus ();

  skew_rd_control #(.WIDTH_HEIGHT(WH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WH*AW-1:0] obs, input logic [WH*AW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the k-th RUN cycle of a tile starting at base.
  function automatic exp_t model(input logic [AW-1:0] base, input int k);
    exp_t e;
    e.en   = '0;
    e.addr = '0;
    e.busy = 1'b1;
    e.done = 1'b0;
    for (int i = 0; i < WH; i++) begin
      if (k >= i && k < i + WH) begin
        e.en[i]            = 1'b1;
        e.addr[i*AW +: AW] = base + AW'(k - i);
      end
    end
    return e;
  endfunction

  task automatic push_tile(input logic [AW-1:0] base, input int stall_at, input int stall_len);
    exp_t fin;
    for (int k = 0; k < 2*WH-1; k++) begin
      sb.push_back(model(base, k));
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) sb.push_back(model(base, k));
      end
    end
    fin.en   = '0;
    fin.addr = '0;
    fin.busy = 1'b0;
    fin.done = 1'b1;
    sb.push_back(fin);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".rd_en"},   (WH*AW)'(bus.rd_en), (WH*AW)'(e.en));
      chk({tag, ".rd_addr"}, bus.rd_addr,         e.addr);
      chk({tag, ".busy"},    (WH*AW)'(bus.busy),  (WH*AW)'(e.busy));
      chk({tag, ".done"},    (WH*AW)'(bus.done),  (WH*AW)'(e.done));
    end
  endtask

  // Start a tile, then walk the scoreboard one cycle at a time.
  // spot: 1 = plain tile landmarks at base 0x10, 2 = wrap landmarks at base 0xF8.
  task automatic run_tile(input logic [AW-1:0] base, input int ign_at, input logic [AW-1:0] ign_base,
                          input int stall_at, input int stall_len, input int spot);
    int n;
    string tag;
    logic [AW-1:0] lane0, lane15;
    push_tile(base, stall_at, stall_len);
    n = 2*WH + stall_len;
    bus.start     = 1'b1;
    bus.base_addr = base;
    tick();
    bus.start          = 1'b0;
    bus.sys_arr_active = 1'b0;
    bus.base_addr      = '0;
    for (int j = 0; j < n; j++) begin
      tag    = $sformatf("tile%02h[%0d]", base, j);
      lane0  = bus.rd_addr[0 +: AW];
      lane15 = bus.rd_addr[(WH-1)*AW +: AW];
      if (spot == 1 && j == 0) begin
        chk({tag, ".first_en"}, (WH*AW)'(bus.rd_en), 'h0001);
        chk({tag, ".first_l0"}, (WH*AW)'(lane0), 'h10);
      end
      if (spot == 1 && j == 15) begin
        chk({tag, ".full_en"}, (WH*AW)'(bus.rd_en), 'hFFFF);
        chk({tag, ".full_l0"}, (WH*AW)'(lane0), 'h1F);
        chk({tag, ".full_l15"}, (WH*AW)'(lane15), 'h10);
      end
      if (spot == 1 && j == 30) begin
        chk({tag, ".last_en"}, (WH*AW)'(bus.rd_en), 'h8000);
        chk({tag, ".last_l15"}, (WH*AW)'(lane15), 'h1F);
      end
      if (spot == 1 && j == 31) begin
        chk({tag, ".cmpl_done"}, (WH*AW)'(bus.done), 1);
      end
      if (spot == 2 && j == 7) chk({tag, ".wrap_ff"}, (WH*AW)'(lane0), 'hFF);
      if (spot == 2 && j == 8) begin
        chk({tag, ".wrap_00"}, (WH*AW)'(lane0), 'h00);
        chk({tag, ".wrap_en0"}, (WH*AW)'(bus.rd_en[0]), 1);
      end
      check_pop(tag);
      if (j < n - 1) begin
        if (j == ign_at) begin
          bus.start     = 1'b1;
          bus.base_addr = ign_base;
        end
`ifdef SKEW_RD_STALL_EN
        bus.stall = (stall_len > 0) && (j >= stall_at) && (j < stall_at + stall_len);
`endif
        tick();
        bus.start     = 1'b0;
        bus.base_addr = '0;
      end
    end
`ifdef SKEW_RD_STALL_EN
    bus.stall = 1'b0;
`endif
  endtask

  initial begin
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.base_addr      = '0;
    bus.sys_arr_active = 1'b0;
`ifdef SKEW_RD_STALL_EN
    bus.stall          = 1'b0;
`endif
    tick();
    tick();

    // Reset values.
    chk("rst.rd_en",   (WH*AW)'(bus.rd_en), 0);
    chk("rst.rd_addr", bus.rd_addr,         0);
    chk("rst.busy",    (WH*AW)'(bus.busy),  0);
    chk("rst.done",    (WH*AW)'(bus.done),  0);
    reset = 1'b0;
    tick();

    // Base 0x10 with an ignored start (base 0x80) five cycles in.
    run_tile(8'h10, 4, 8'h80, -1, 0, 1);
    tick();
    chk("sticky.done", (WH*AW)'(bus.done), 1);
    chk("sticky.busy", (WH*AW)'(bus.busy), 0);

    // A new start clears done; a start on the completing edge is ignored.
    run_tile(8'h40, 30, 8'hA0, -1, 0, 0);

    // Back-to-back start together with sys_arr_active: start wins, wrap at 0xFF.
    bus.sys_arr_active = 1'b1;
    run_tile(8'hF8, -1, 8'h00, -1, 0, 2);

    // sys_arr_active clears done.
    bus.sys_arr_active = 1'b1;
    tick();
    bus.sys_arr_active = 1'b0;
    chk("ack.done",  (WH*AW)'(bus.done),  0);
    chk("ack.rd_en", (WH*AW)'(bus.rd_en), 0);
    tick();
    chk("ack.hold",  (WH*AW)'(bus.done),  0);

    // Reset ten cycles into a tile, with start held on the reset edge.
    bus.start     = 1'b1;
    bus.base_addr = 8'h20;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("midrun.busy_before", (WH*AW)'(bus.busy), 1);
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("midrun.rd_en",   (WH*AW)'(bus.rd_en), 0);
    chk("midrun.rd_addr", bus.rd_addr,         0);
    chk("midrun.busy",    (WH*AW)'(bus.busy),  0);
    chk("midrun.done",    (WH*AW)'(bus.done),  0);
    tick();
    chk("midrun.idle", (WH*AW)'(bus.busy), 0);
    run_tile(8'h30, -1, 8'h00, -1, 0, 0);

`ifdef SKEW_RD_STALL_EN
    // Three stall cycles at cnt=5 delay completion by three cycles.
    tick();
    run_tile(8'h10, -1, 8'h00, 5, 3, 1);
`endif

    chk("sb.drained", (WH*AW)'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_rd_control.md
Name: skew_rd_control

Overview:
Upstream companion to the result-write controller. Generates diagonally skewed read enables and per-lane addresses for the input (weight/activation) memory array so that a WIDTH_HEIGHT x WIDTH_HEIGHT tile streams into the systolic array with lane i lagging lane 0 by i cycles. Started by a one-cycle request from the top-level sequencer; reports completion via a sticky done flag.

Parameters:
WIDTH_HEIGHT, 16, systolic array dimension = number of memory lanes = rows read per lane
ADDR_W, 8, per-lane memory address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a tile read
base_addr  input  ADDR_W  first address read in every lane; sampled when start is accepted
sys_arr_active  input  1  systolic array running; clears done
rd_en  output  WIDTH_HEIGHT  per-lane read enable, bit i = lane i
rd_addr  output  WIDTH_HEIGHT*ADDR_W  per-lane address, lane i at bits [i*ADDR_W +: ADDR_W]
busy  output  1  high while the tile read is in progress
done  output  1  sticky completion flag

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- All outputs are registered.
- Reset values: rd_en=0, rd_addr=0, busy=0, done=0, state=IDLE, cnt=0, base register=0.
- FSM has two states: IDLE and RUN.
- IDLE, start=1 at edge t0:
  - Capture base_addr.
  - Go to RUN with cnt=0 at t0.
  - busy=1 and done=0 from t0.
- RUN: cnt increments by 1 per clock, from 0 to 2*WIDTH_HEIGHT-2, for 2W-1 active cycles.
  - Lane i enable: rd_en[i] = (cnt >= i) && (cnt < i+WIDTH_HEIGHT).
  - Lane i address: rd_addr lane i = base + (cnt - i) mod 2^ADDR_W while enabled, otherwise 0.
  - Result: each lane reads addresses base .. base+W-1 exactly once, in ascending order.
- rd_en pattern: 0x0001, 0x0003, ... 0xFFFF (cnt=W-1), 0xFFFE, ... 0x8000 (cnt=2W-2).
- Edge after cnt=2W-2:
  - rd_en=0, rd_addr=0, busy=0, done=1.
  - Return to IDLE.
- Latency: first enable is visible in the cycle after the edge that samples start. Last enable falls 2W-1 cycles after that.
- done is cleared by either of:
  - the edge where sys_arr_active=1 && done=1;
  - acceptance of a new start.
- If a start arrives on the same edge where done would be set: done is set first, and that start is ignored because the state is not yet IDLE.
- start while in RUN is ignored, with no queuing. base_addr changes during RUN have no effect.
- start and the done-clearing condition on the same edge: start wins, so done=0 and RUN is entered.
- Address arithmetic wraps modulo 2^ADDR_W. No error is flagged.
- Reset mid-RUN forces all reset values on that edge, regardless of start.
- Back-to-back operation: a start on the first IDLE cycle after completion begins a new tile immediately. That gives one idle bubble between tiles.

Optional Feature:
Macro SKEW_RD_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in RUN, cnt, rd_en and rd_addr hold their values and no progress is made.
  - The memory must treat held enables as a repeat read; addresses do not advance.
  - stall in IDLE has no effect.
  - start is still accepted in IDLE while stall=1.
  - The first RUN cycle is stallable.
- Undefined: no stall port; RUN always advances every cycle.

Decomposition:
- Shared package:
  - defaults for WIDTH_HEIGHT and ADDR_W;
  - FSM state encoding (IDLE, RUN);
  - cycle-count width, $clog2(2*WIDTH_HEIGHT-1).
  - wr_control uses the same package.
- One natural sub-module, skew_rd_lane:
  - parameterized by lane index;
  - takes cnt and base;
  - produces that lane's enable and address.
  - Generated WIDTH_HEIGHT times.

Test Plan:
- Reset-then-start: W=16, base_addr=0x10, start pulse at t0.
  - t0+1: rd_en=0x0001, lane0 addr=0x10.
  - t0+16: rd_en=0xFFFF, lane0=0x1F, lane15=0x10.
  - t0+31: rd_en=0x8000, lane15=0x1F.
  - t0+32: rd_en=0, busy=0, done=1.
- Done handshake: done=1, hold sys_arr_active=1 one cycle -> done=0 next edge. Repeat with a start instead -> done=0 and rd_en=0x0001 next cycle.
- Ignored start: second start with base_addr=0x80 at t0+5 -> sequence is unchanged, all addresses still in 0x10–0x1F, completion still at t0+32.
- Wrap: base_addr=0xF8 -> lane0 reads 0xF8..0xFF then 0x00..0x07. No enable glitch at the wrap.
- Reset mid-run: reset asserted at t0+10 -> next edge rd_en=0, rd_addr=0, busy=0, done=0. A start after reset restarts from 0x0001.
- SKEW_RD_STALL_EN: stall=1 for 3 cycles at cnt=5 -> rd_en=0x003F and addresses held for 3 cycles. Completion is delayed by exactly 3 cycles, to t0+35.
